// File: rtl/dlx_fetch_pkg.sv
// Shared definitions for the DLX instruction fetch front end: word geometry,
// PC increment, NOP encoding and the queued-instruction record.
package dlx_fetch_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [WORD_W-1:0] PC_INCR   = WORD_W'(INSTR_BYTES);
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0020;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pcPlus4;
    } pfq_entry_t;

    // Sequential successor of a fetch address; wraps naturally at 2^32.
    function automatic logic [WORD_W-1:0] nextPc(input logic [WORD_W-1:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/pfq_fifo.sv
// Small synchronous FIFO with flush; head word is visible combinationally
// and reads as zero while the FIFO is empty.
module pfq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rdPtr;
    logic [AW-1:0]    r_wrPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == CW'(DEPTH));
    assign count    = r_count;
    assign w_doPop  = pop && !empty;
    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign w_doPush = push && (!full || w_doPop);
    assign rdata    = empty ? '0 : r_mem[r_rdPtr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush && !flush) r_mem[r_wrPtr] <= wdata;
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch front end: runs sequential fetches ahead of Decode,
// queues returned words with their PC+4, and squashes stale work on a redirect.
module instr_prefetch_queue
    import dlx_fetch_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter logic [WORD_W-1:0] INIT_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_addr,
    input  logic              stall,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc_plus_four
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WORD_W-1:0] r_fetchPc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop;

    logic              w_credit;
    logic              w_resp;
    logic              w_accept;
    logic              w_pop;
    logic [CW-1:0]     w_outNext;
    pfq_entry_t        w_iqIn;
    pfq_entry_t        w_iqHead;
    logic [CW-1:0]     w_iqCount;
    logic              w_iqFull;
    logic              w_iqEmpty;
    logic [WORD_W-1:0] w_tqHead;
    logic [CW-1:0]     w_tqCount;
    logic              w_tqFull;
    logic              w_tqEmpty;

    // Queued plus in-flight words never exceed the queue size, so every response has a slot.
    assign w_credit  = ({1'b0, w_iqCount} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
    assign imem_req  = !reset && !redirect_valid && w_credit;
    assign imem_addr = r_fetchPc;

    assign w_resp    = imem_rvalid && (r_outstanding != '0);
    assign w_accept  = w_resp && (r_drop == '0) && !redirect_valid;
    assign w_outNext = r_outstanding + CW'(imem_req) - CW'(w_resp);

    assign instr_valid        = !w_iqEmpty && !redirect_valid;
    assign w_pop              = instr_valid && !stall;
    assign instr              = w_iqHead.instr;
    assign instr_pc_plus_four = w_iqHead.pcPlus4;

    assign w_iqIn.instr   = imem_rdata;
    assign w_iqIn.pcPlus4 = w_tqHead;

    // On a redirect every request still in flight becomes a response to throw away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetchPc     <= INIT_ADDR;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_outNext;
            if (redirect_valid) begin
                r_fetchPc <= redirect_addr;
                r_drop    <= r_outstanding - CW'(w_resp);
            end else begin
                if (imem_req) r_fetchPc <= nextPc(r_fetchPc);
                if (w_resp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            end
        end
    end

    pfq_fifo #(
        .WIDTH ($bits(pfq_entry_t)),
        .DEPTH (DEPTH)
    ) u_instrQ (
        .clk   (clk),
        .reset (reset),
        .push  (w_accept),
        .pop   (w_pop),
        .flush (redirect_valid),
        .wdata (w_iqIn),
        .rdata (w_iqHead),
        .count (w_iqCount),
        .full  (w_iqFull),
        .empty (w_iqEmpty)
    );

    // Holds PC+4 of each live request; squashed requests lose their tag at the redirect.
    pfq_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_tagQ (
        .clk   (clk),
        .reset (reset),
        .push  (imem_req),
        .pop   (w_accept),
        .flush (redirect_valid),
        .wdata (nextPc(r_fetchPc)),
        .rdata (w_tqHead),
        .count (w_tqCount),
        .full  (w_tqFull),
        .empty (w_tqEmpty)
    );

    a_noQueueOverflow: assert property (@(posedge clk) disable iff (reset)
        !(w_accept && w_iqFull && !w_pop));
    a_noStrayResponse: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (r_outstanding == '0)));
    a_tagsMatchLive: assert property (@(posedge clk) disable iff (reset)
        w_tqCount == (r_outstanding - r_drop));
    a_tagNoUnderflow: assert property (@(posedge clk) disable iff (reset)
        !(w_accept && w_tqEmpty));
    a_tagNoOverflow: assert property (@(posedge clk) disable iff (reset)
        !(imem_req && w_tqFull));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: an in-order memory model with
// configurable latency and a queue-level reference model compared every cycle.
module tb_instr_prefetch_queue;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] INIT_ADDR = 32'h0000_0100;

    logic        clk                = 1'b0;
    logic        reset              = 1'b0;
    logic        redirect_valid     = 1'b0;
    logic [31:0] redirect_addr      = '0;
    logic        stall              = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid        = 1'b0;
    logic [31:0] imem_rdata         = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc_plus_four;

    instr_prefetch_queue #(
        .DEPTH     (DEPTH),
        .INIT_ADDR (INIT_ADDR)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .redirect_valid     (redirect_valid),
        .redirect_addr      (redirect_addr),
        .stall              (stall),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_rvalid        (imem_rvalid),
        .imem_rdata         (imem_rdata),
        .instr_valid        (instr_valid),
        .instr              (instr),
        .instr_pc_plus_four (instr_pc_plus_four)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] instr; logic [31:0] pcPlus4; } qEntry_t;
    typedef struct { logic [31:0] pcPlus4; bit stale; } osEntry_t;
    typedef struct { logic [31:0] addr; int issue; } memReq_t;

    // Reference model: delivered-but-unconsumed words, and requests awaiting a response.
    qEntry_t     mQueue[$];
    osEntry_t    mOut[$];
    logic [31:0] mPc;

    memReq_t     memQ[$];
    int          memLat = 1;

    logic [31:0] reqLog[$];
    logic [31:0] popLog[$];
    logic [31:0] popInstrLog[$];
    int          firstValidCycle = 0;
    int          cycleNo = 1;
    logic        lastReq;
    logic        lastValid;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic logic [31:0] reqAt(input int i);
        return (i < reqLog.size()) ? reqLog[i] : 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] popAt(input int i);
        return (i < popLog.size()) ? popLog[i] : 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] popInstrAt(input int i);
        return (i < popInstrLog.size()) ? popInstrLog[i] : 32'hBAD0_BAD0;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cycleNo);
        end
    endtask

    task automatic clearLogs();
        reqLog.delete();
        popLog.delete();
        popInstrLog.delete();
        firstValidCycle = 0;
    endtask

    task automatic checkOutput(output bit expReq, output bit expValid);
        logic [31:0] expInstr;
        logic [31:0] expPcp4;
        expReq   = !redirect_valid && ((mQueue.size() + mOut.size()) < DEPTH);
        expValid = (mQueue.size() != 0) && !redirect_valid;
        expInstr = (mQueue.size() != 0) ? mQueue[0].instr   : 32'h0;
        expPcp4  = (mQueue.size() != 0) ? mQueue[0].pcPlus4 : 32'h0;
        checkVal("imem_req", 32'(imem_req), 32'(expReq));
        if (expReq) checkVal("imem_addr", imem_addr, mPc);
        checkVal("instr_valid", 32'(instr_valid), 32'(expValid));
        checkVal("instr", instr, expInstr);
        checkVal("instr_pc_plus_four", instr_pc_plus_four, expPcp4);
    endtask

    // One clock cycle: drive inputs after a falling edge, compare, advance model and memory.
    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] ra);
        bit       expReq;
        bit       expValid;
        osEntry_t oe;
        qEntry_t  qe;
        memReq_t  mr;
        stall          = st;
        redirect_valid = rd;
        redirect_addr  = ra;
        if (memQ.size() > 0 && cycleNo >= memQ[0].issue + memLat) begin
            mr          = memQ.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = instrOf(mr.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        checkOutput(expReq, expValid);

        lastReq   = imem_req;
        lastValid = instr_valid;
        if (imem_req) begin
            reqLog.push_back(imem_addr);
            mr.addr  = imem_addr;
            mr.issue = cycleNo;
            memQ.push_back(mr);
        end
        if (instr_valid && !stall) begin
            popLog.push_back(instr_pc_plus_four);
            popInstrLog.push_back(instr);
        end
        if (instr_valid && firstValidCycle == 0) firstValidCycle = cycleNo;

        if (redirect_valid) begin
            mQueue.delete();
            if (imem_rvalid && mOut.size() > 0) void'(mOut.pop_front());
            foreach (mOut[i]) mOut[i].stale = 1'b1;
            mPc = redirect_addr;
        end else begin
            if (expValid && !stall) void'(mQueue.pop_front());
            if (imem_rvalid && mOut.size() > 0) begin
                oe = mOut.pop_front();
                if (!oe.stale) begin
                    qe.instr   = imem_rdata;
                    qe.pcPlus4 = oe.pcPlus4;
                    mQueue.push_back(qe);
                end
            end
            if (expReq) begin
                oe.pcPlus4 = mPc + 32'd4;
                oe.stale   = 1'b0;
                mOut.push_back(oe);
                mPc = mPc + 32'd4;
            end
        end
        @(negedge clk);
        cycleNo++;
    endtask

    task automatic runCycles(input int n, input logic st);
        for (int i = 0; i < n; i++) applyStimulus(st, 1'b0, 32'h0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic applyReset();
        #2;
        reset          = 1'b1;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        checkVal("rst_imem_req", 32'(imem_req), 32'h0);
        checkVal("rst_instr_valid", 32'(instr_valid), 32'h0);
        checkVal("rst_instr", instr, 32'h0);
        checkVal("rst_pc_plus_four", instr_pc_plus_four, 32'h0);
        @(negedge clk);
        @(negedge clk);
        mQueue.delete();
        mOut.delete();
        memQ.delete();
        mPc = INIT_ADDR;
        clearLogs();
        reset   = 1'b0;
        cycleNo = 1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Streaming fetch with single-cycle memory.
        applyReset();
        memLat = 1;
        runCycles(8, 1'b0);
        checkVal("s1_req0", reqAt(0), 32'h0000_0100);
        checkVal("s1_req1", reqAt(1), 32'h0000_0104);
        checkVal("s1_req2", reqAt(2), 32'h0000_0108);
        checkVal("s1_first_valid_cycle", 32'(firstValidCycle), 32'd3);
        checkVal("s1_pop0", popAt(0), 32'h0000_0104);
        checkVal("s1_pop1", popAt(1), 32'h0000_0108);
        checkVal("s1_pop0_instr", popInstrAt(0), 32'hC0DE_0100);

        // Long stall: credit limit caps issue at DEPTH, then release drains in order.
        applyReset();
        runCycles(10, 1'b1);
        checkVal("s2_req_count", 32'(reqLog.size()), 32'd4);
        checkVal("s2_req_after_fill", 32'(lastReq), 32'h0);
        clearLogs();
        runCycles(8, 1'b0);
        checkVal("s2_pop0", popAt(0), 32'h0000_0104);
        checkVal("s2_pop1", popAt(1), 32'h0000_0108);
        checkVal("s2_pop2", popAt(2), 32'h0000_010C);
        checkVal("s2_pop3", popAt(3), 32'h0000_0110);
        checkVal("s2_resume_addr", reqAt(0), 32'h0000_0110);

        // Address wrap at the top of the 32-bit space.
        clearLogs();
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
        runCycles(8, 1'b0);
        checkVal("s5_req0", reqAt(0), 32'hFFFF_FFF8);
        checkVal("s5_req1", reqAt(1), 32'hFFFF_FFFC);
        checkVal("s5_req2", reqAt(2), 32'h0000_0000);
        checkVal("s5_pop0", popAt(0), 32'hFFFF_FFFC);
        checkVal("s5_pop1", popAt(1), 32'h0000_0000);
        checkVal("s5_pop2", popAt(2), 32'h0000_0004);

        // Redirect with three requests in flight on a 3-cycle memory.
        applyReset();
        memLat = 3;
        runCycles(3, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_2000);
        runCycles(10, 1'b0);
        checkVal("s3_first_valid_cycle", 32'(firstValidCycle), 32'd9);
        checkVal("s3_pop0", popAt(0), 32'h0000_2004);
        checkVal("s3_pop0_instr", popInstrAt(0), 32'hC0DE_2000);

        // Redirect under stall while a response arrives and the queue holds three words.
        applyReset();
        memLat = 3;
        runCycles(6, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0000_3000);
        checkVal("s4_redirect_req", 32'(lastReq), 32'h0);
        checkVal("s4_redirect_valid", 32'(lastValid), 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkVal("s4_after_flush_valid", 32'(lastValid), 32'h0);
        clearLogs();
        runCycles(8, 1'b0);
        checkVal("s4_pop0", popAt(0), 32'h0000_3004);
        checkVal("s4_pop0_instr", popInstrAt(0), 32'hC0DE_3000);

        // Reset while words are queued and a request is outstanding.
        applyReset();
        memLat = 3;
        runCycles(6, 1'b1);
        applyReset();
        memLat = 1;
        runCycles(5, 1'b0);
        checkVal("s6_restart_addr", reqAt(0), INIT_ADDR);
        checkVal("s6_first_valid_cycle", 32'(firstValidCycle), 32'd3);
        checkVal("s6_pop0", popAt(0), 32'h0000_0104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
